// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one SPI flash bus slave between two requesters with round-robin
// grant, rty back-off/re-issue, a per-attempt watchdog and enforced strobe release.
module flash_arbiter #(
   parameter int RETRY_DELAY    = 1000,
   parameter int MAX_RETRIES    = 15,
   parameter int TIMEOUT        = 65535,
   parameter int RELEASE_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [23:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic        m0_we_i,
   input  logic        m0_stb_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [23:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic        m1_we_i,
   input  logic        m1_stb_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [23:0] f_adr_o,
   output logic [31:0] f_dat_o,
   output logic        f_we_o,
   output logic        f_stb_o,
   input  logic [31:0] f_dat_i,
   input  logic        f_ack_i,
   input  logic        f_rty_i,
   output logic        busy_o,
   output logic        grant_o
);

   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(RETRY_DELAY + 1);
   localparam int LW = $clog2(RELEASE_CYCLES + 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [BW-1:0] BO_LAST    = BW'(RETRY_DELAY - 1);
   localparam logic [LW-1:0] REL_LAST   = LW'(RELEASE_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF, S_RELEASE} state_t;

   state_t        state, state_nxt;
   logic [23:0]   adr_q;
   logic [31:0]   dat_q;
   logic          we_q;
   logic          last_grant;
   logic          mask_first;
   logic [RW-1:0] retry_cnt;
   logic [TW-1:0] timeout_cnt;
   logic [BW-1:0] backoff_cnt;
   logic [LW-1:0] rel_cnt;
   logic          req0, req1;
   logic          grant_req, grant_sel;
   logic          done_ack, done_err, do_retry;

   // The bus only ever sees the latched request; strobe is high exactly in WAIT.
   assign f_adr_o = adr_q;
   assign f_dat_o = dat_q;
   assign f_we_o  = we_q;
   assign f_stb_o = (state == S_WAIT);
   assign busy_o  = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      grant_req = 1'b0;
      grant_sel = 1'b0;
      done_ack  = 1'b0;
      done_err  = 1'b0;
      do_retry  = 1'b0;
      // The port just served may still hold stb for one cycle after its ack/err.
      req0 = m0_stb_i && !(mask_first && !last_grant);
      req1 = m1_stb_i && !(mask_first && last_grant);
      case (state)
         S_IDLE: begin
            if (req0 || req1) begin
               grant_req = 1'b1;
               grant_sel = (req0 && req1) ? ~last_grant : req1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (f_ack_i) begin
               done_ack  = 1'b1;
               state_nxt = S_RELEASE;
            end else if (f_rty_i) begin
               if (retry_cnt == RETRY_LAST) begin
                  done_err  = 1'b1;
                  state_nxt = S_RELEASE;
               end else begin
                  do_retry  = 1'b1;
                  state_nxt = S_BACKOFF;
               end
            end else if (timeout_cnt == TO_LAST) begin
               done_err  = 1'b1;
               state_nxt = S_RELEASE;
            end
         end
         S_BACKOFF: if (backoff_cnt == BO_LAST) state_nxt = S_ISSUE;
         S_RELEASE: if (rel_cnt == REL_LAST) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         adr_q       <= '0;
         dat_q       <= '0;
         we_q        <= 1'b0;
         last_grant  <= 1'b1;
         grant_o     <= 1'b0;
         mask_first  <= 1'b0;
         retry_cnt   <= '0;
         timeout_cnt <= '0;
         backoff_cnt <= '0;
         rel_cnt     <= '0;
         m0_dat_o    <= '0;
         m0_ack_o    <= 1'b0;
         m0_err_o    <= 1'b0;
         m1_dat_o    <= '0;
         m1_ack_o    <= 1'b0;
         m1_err_o    <= 1'b0;
      end else begin
         state      <= state_nxt;
         mask_first <= (state == S_RELEASE) && (state_nxt == S_IDLE);

         if (grant_req) begin
            adr_q      <= grant_sel ? m1_adr_i : m0_adr_i;
            dat_q      <= grant_sel ? m1_dat_i : m0_dat_i;
            we_q       <= grant_sel ? m1_we_i  : m0_we_i;
            last_grant <= grant_sel;
            grant_o    <= grant_sel;
            retry_cnt  <= '0;
         end else if (do_retry) begin
            retry_cnt <= retry_cnt + RW'(1);
         end

         if (state == S_ISSUE)
            timeout_cnt <= '0;
         else if (state == S_WAIT && timeout_cnt != TO_LAST)
            timeout_cnt <= timeout_cnt + TW'(1);

         if (state != S_BACKOFF)
            backoff_cnt <= '0;
         else if (backoff_cnt != BO_LAST)
            backoff_cnt <= backoff_cnt + BW'(1);

         if (state != S_RELEASE)
            rel_cnt <= '0;
         else if (rel_cnt != REL_LAST)
            rel_cnt <= rel_cnt + LW'(1);

         // Completion pulses go to the granted port only and last one cycle.
         m0_ack_o <= done_ack && !grant_o;
         m1_ack_o <= done_ack && grant_o;
         m0_err_o <= done_err && !grant_o;
         m1_err_o <= done_err && grant_o;
         if (done_ack && !grant_o) m0_dat_o <= f_dat_i;
         if (done_ack && grant_o)  m1_dat_o <= f_dat_i;
      end
   end

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed checks of grant order, retry/back-off, timeout, release and reset.
module tb_flash_arbiter;

   localparam int RETRY_DELAY    = 1000;
   localparam int MAX_RETRIES    = 15;
   localparam int TIMEOUT        = 3000;
   localparam int RELEASE_CYCLES = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [23:0] m0_adr_i, m1_adr_i;
   logic [31:0] m0_dat_i, m1_dat_i;
   logic        m0_we_i, m1_we_i, m0_stb_i, m1_stb_i;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [23:0] f_adr_o;
   logic [31:0] f_dat_o, f_dat_i;
   logic        f_we_o, f_stb_o, f_ack_i, f_rty_i;
   logic        busy_o, grant_o;

   int nCompared   = 0;
   int nMismatched = 0;

   int          stbRises = 0, adrGlitch = 0, clash = 0;
   int          ack0Cnt = 0, ack1Cnt = 0, err0Cnt = 0, err1Cnt = 0;
   logic        stbPrev = 1'b0;
   logic [23:0] adrPrev = '0;

   flash_arbiter #(
      .RETRY_DELAY(RETRY_DELAY), .MAX_RETRIES(MAX_RETRIES),
      .TIMEOUT(TIMEOUT), .RELEASE_CYCLES(RELEASE_CYCLES)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .f_adr_o(f_adr_o), .f_dat_o(f_dat_o), .f_we_o(f_we_o), .f_stb_o(f_stb_o),
      .f_dat_i(f_dat_i), .f_ack_i(f_ack_i), .f_rty_i(f_rty_i),
      .busy_o(busy_o), .grant_o(grant_o)
   );

   always #5 clk_i = ~clk_i;

   // Bus monitor: strobe edges, address stability under strobe, pulse counts and clashes.
   always @(negedge clk_i) begin
      if (f_stb_o && !stbPrev) stbRises++;
      if (f_stb_o && stbPrev && f_adr_o != adrPrev) adrGlitch++;
      if (m0_ack_o) ack0Cnt++;
      if (m1_ack_o) ack1Cnt++;
      if (m0_err_o) err0Cnt++;
      if (m1_err_o) err1Cnt++;
      if ((m0_ack_o || m0_err_o) && (m1_ack_o || m1_err_o)) clash++;
      if ((m0_ack_o && m0_err_o) || (m1_ack_o && m1_err_o)) clash++;
      stbPrev = f_stb_o;
      adrPrev = f_adr_o;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL global time limit: observed hang expected completion");
      $fatal(1, "[TB] time limit");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int port, input logic [23:0] adr,
                                input logic [31:0] dat, input logic we, input logic stb);
      if (port == 0) begin
         m0_adr_i = adr; m0_dat_i = dat; m0_we_i = we; m0_stb_i = stb;
      end else begin
         m1_adr_i = adr; m1_dat_i = dat; m1_we_i = we; m1_stb_i = stb;
      end
   endtask

   task automatic doReset();
      rst_i = 1'b1;
      repeat (3) tick();
      rst_i = 1'b0;
   endtask

   task automatic waitStb(input string tag, input int limit, output int cyc);
      cyc = 0;
      while (!f_stb_o && cyc < limit) begin
         tick();
         cyc++;
      end
      if (!f_stb_o) checkOutput({tag, " strobe wait expired"}, 32'd0, 32'd1);
   endtask

   task automatic flashReply(input logic ack, input logic rty, input logic [31:0] dat);
      f_ack_i = ack; f_rty_i = rty; f_dat_i = dat;
      tick();
      f_ack_i = 1'b0; f_rty_i = 1'b0; f_dat_i = '0;
   endtask

   // Called on the first RELEASE sample (the one showing the ack/err pulse).
   task automatic releaseCheck(input string tag);
      int   lowCnt;
      logic stbSeen;
      lowCnt  = 1;
      stbSeen = f_stb_o;
      tick();
      checkOutput({tag, " pulse width"},
                  {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'd0);
      while (busy_o && lowCnt < 100) begin
         lowCnt++;
         stbSeen |= f_stb_o;
         tick();
      end
      checkOutput({tag, " release length"}, lowCnt, RELEASE_CYCLES);
      checkOutput({tag, " stb during release"}, stbSeen, 1'b0);
      checkOutput({tag, " idle after release"}, busy_o, 1'b0);
   endtask

   initial begin
      int gap, hi, base0, base1, baseE0, baseE1, baseS, baseG;
      applyStimulus(0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1, '0, '0, 1'b0, 1'b0);
      f_dat_i = '0; f_ack_i = 1'b0; f_rty_i = 1'b0;
      doReset();

      checkOutput("reset f_stb", f_stb_o, 1'b0);
      checkOutput("reset busy", busy_o, 1'b0);
      checkOutput("reset grant", grant_o, 1'b0);
      checkOutput("reset pulses", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'd0);
      checkOutput("reset m0_dat", m0_dat_o, 32'd0);
      checkOutput("reset f_adr", f_adr_o, 24'd0);

      // 1: single read, ack after 200 WAIT cycles
      applyStimulus(0, 24'h000100, 32'h0, 1'b0, 1'b1);
      tick();
      checkOutput("t1 stb after 1 cycle", f_stb_o, 1'b0);
      checkOutput("t1 busy", busy_o, 1'b1);
      tick();
      checkOutput("t1 stb after 2 cycles", f_stb_o, 1'b1);
      checkOutput("t1 f_adr", f_adr_o, 24'h000100);
      checkOutput("t1 f_we", f_we_o, 1'b0);
      repeat (199) tick();
      checkOutput("t1 no early ack", m0_ack_o, 1'b0);
      flashReply(1'b1, 1'b0, 32'hDEADBEEF);
      m0_stb_i = 1'b0;
      checkOutput("t1 m0_ack", m0_ack_o, 1'b1);
      checkOutput("t1 m0_dat", m0_dat_o, 32'hDEADBEEF);
      checkOutput("t1 m1_ack", m1_ack_o, 1'b0);
      releaseCheck("t1");

      // 2: contention after reset, m0 re-requests while m1 is still pending
      doReset();
      baseG = adrGlitch;
      applyStimulus(0, 24'h000200, 32'h0, 1'b0, 1'b1);
      applyStimulus(1, 24'h000300, 32'h0, 1'b0, 1'b1);
      waitStb("t2a", 50, gap);
      checkOutput("t2a grant", grant_o, 1'b0);
      checkOutput("t2a f_adr", f_adr_o, 24'h000200);
      repeat (4) tick();
      flashReply(1'b1, 1'b0, 32'h11111111);
      checkOutput("t2a m0_ack", m0_ack_o, 1'b1);
      checkOutput("t2a m0_dat", m0_dat_o, 32'h11111111);
      checkOutput("t2a m1 quiet", {m1_ack_o, m1_err_o, m1_dat_o}, 34'd0);
      m0_stb_i = 1'b0;
      tick();
      applyStimulus(0, 24'h000400, 32'h0, 1'b0, 1'b1);
      waitStb("t2b", 100, gap);
      checkOutput("t2b grant", grant_o, 1'b1);
      checkOutput("t2b f_adr", f_adr_o, 24'h000300);
      repeat (4) tick();
      flashReply(1'b1, 1'b0, 32'h22222222);
      checkOutput("t2b m1_ack", m1_ack_o, 1'b1);
      checkOutput("t2b m1_dat", m1_dat_o, 32'h22222222);
      checkOutput("t2b m0 quiet", {m0_ack_o, m0_err_o}, 2'd0);
      checkOutput("t2b m0_dat held", m0_dat_o, 32'h11111111);
      m1_stb_i = 1'b0;
      waitStb("t2c", 100, gap);
      checkOutput("t2c grant", grant_o, 1'b0);
      checkOutput("t2c f_adr", f_adr_o, 24'h000400);
      m0_adr_i = 24'hABCDEF;
      repeat (4) tick();
      checkOutput("t2c adr ignores input", f_adr_o, 24'h000400);
      flashReply(1'b1, 1'b0, 32'h33333333);
      checkOutput("t2c m0_ack", m0_ack_o, 1'b1);
      checkOutput("t2c m0_dat", m0_dat_o, 32'h33333333);
      m0_stb_i = 1'b0;
      releaseCheck("t2c");
      checkOutput("t2 adr stable under stb", adrGlitch - baseG, 0);

      // 3: m1 gets rty three times, then ack coincident with rty
      baseS = stbRises; base1 = ack1Cnt; baseE1 = err1Cnt;
      applyStimulus(1, 24'h000500, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         waitStb("t3", 2000, gap);
         if (i > 0) checkOutput("t3 backoff gap >= 1000", (gap >= 1000), 1'b1);
         repeat (2) tick();
         if (i < 3) begin
            flashReply(1'b0, 1'b1, 32'h0);
            checkOutput("t3 no err on retry", m1_err_o, 1'b0);
            checkOutput("t3 stb low on retry", f_stb_o, 1'b0);
         end
      end
      flashReply(1'b1, 1'b1, 32'hCAFEF00D);
      m1_stb_i = 1'b0;
      checkOutput("t3 m1_ack", m1_ack_o, 1'b1);
      checkOutput("t3 m1_err", m1_err_o, 1'b0);
      checkOutput("t3 m1_dat", m1_dat_o, 32'hCAFEF00D);
      releaseCheck("t3");
      checkOutput("t3 strobe count", stbRises - baseS, 4);
      checkOutput("t3 ack count", ack1Cnt - base1, 1);
      checkOutput("t3 err count", err1Cnt - baseE1, 0);

      // 4: rty forever on m0
      baseS = stbRises; base0 = ack0Cnt; baseE0 = err0Cnt;
      applyStimulus(0, 24'h000600, 32'h12345678, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         waitStb("t4", 2000, gap);
         if (i == 0) checkOutput("t4 f_we", f_we_o, 1'b1);
         tick();
         flashReply(1'b0, 1'b1, 32'h0);
         if (i < 15) checkOutput("t4 no early err", m0_err_o, 1'b0);
      end
      m0_stb_i = 1'b0;
      checkOutput("t4 m0_err", m0_err_o, 1'b1);
      checkOutput("t4 m0_ack", m0_ack_o, 1'b0);
      releaseCheck("t4");
      checkOutput("t4 strobe count", stbRises - baseS, 16);
      checkOutput("t4 err count", err0Cnt - baseE0, 1);
      checkOutput("t4 ack count", ack0Cnt - base0, 0);

      // 5a: flash silent, watchdog fires after TIMEOUT WAIT cycles
      applyStimulus(0, 24'h000700, 32'h0, 1'b0, 1'b1);
      waitStb("t5a", 100, gap);
      hi = 0;
      while (f_stb_o && hi < TIMEOUT + 10) begin
         hi++;
         tick();
      end
      m0_stb_i = 1'b0;
      checkOutput("t5a stb high cycles", hi, TIMEOUT);
      checkOutput("t5a m0_err", m0_err_o, 1'b1);
      checkOutput("t5a m0_ack", m0_ack_o, 1'b0);
      releaseCheck("t5a");

      // 5b: reset during WAIT aborts silently; m0 wins next contention
      base1 = ack1Cnt; baseE1 = err1Cnt;
      applyStimulus(1, 24'h000800, 32'h0, 1'b0, 1'b1);
      waitStb("t5b", 100, gap);
      checkOutput("t5b grant before reset", grant_o, 1'b1);
      repeat (10) tick();
      rst_i = 1'b1;
      tick();
      checkOutput("t5b stb after reset", f_stb_o, 1'b0);
      checkOutput("t5b busy after reset", busy_o, 1'b0);
      checkOutput("t5b grant after reset", grant_o, 1'b0);
      rst_i = 1'b0;
      applyStimulus(0, 24'h000900, 32'h0, 1'b0, 1'b1);
      waitStb("t5b regrant", 100, gap);
      checkOutput("t5b regrant port", grant_o, 1'b0);
      checkOutput("t5b regrant f_adr", f_adr_o, 24'h000900);
      checkOutput("t5b no pulse on abort", (ack1Cnt - base1) + (err1Cnt - baseE1), 0);
      repeat (3) tick();
      flashReply(1'b1, 1'b0, 32'h0BADF00D);
      applyStimulus(0, 24'h0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1, 24'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("t5b m0_ack", m0_ack_o, 1'b1);
      checkOutput("t5b m0_dat", m0_dat_o, 32'h0BADF00D);
      repeat (20) tick();
      checkOutput("pulse clashes", clash, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares the single SPI flash bus slave (24-bit address, 32-bit data, stb/ack/rty handshake) between two requesters.
  - Port 0: sample/patch loader.
  - Port 1: configuration reader.
- Arbitrates round-robin and latches the winning request.
- Owns retry sequencing: on flash rty (device busy) it backs off and re-issues, up to a limit.
- Enforces strobe release between transactions so the flash controller returns to idle, and watchdogs each attempt.

Parameters:
- RETRY_DELAY, 1000: clk_i cycles spent in BACKOFF after each rty before re-issuing.
- MAX_RETRIES, 15: rty responses tolerated per transaction; the next rty is reported as error.
- TIMEOUT, 65535: max clk_i cycles in WAIT per attempt before error.
- RELEASE_CYCLES, 16: cycles f_stb_o is held low after every ack/rty/timeout. Must exceed the flash baud divider (5).

Ports:
- clk_i, input, 1: system clock, 100 MHz.
- rst_i, input, 1: synchronous active-high reset.
- m0_adr_i, input, 24: requester 0 byte address.
- m0_dat_i, input, 32: requester 0 write data.
- m0_we_i, input, 1: requester 0 write enable.
- m0_stb_i, input, 1: requester 0 request; held until ack or err.
- m0_dat_o, output, 32: read data to requester 0, valid with m0_ack_o.
- m0_ack_o, output, 1: one-cycle completion pulse.
- m0_err_o, output, 1: one-cycle failure pulse (retries exhausted or timeout).
- m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_dat_o, m1_ack_o, m1_err_o: same as port 0, for requester 1.
- f_adr_o, output, 24: address to flash controller.
- f_dat_o, output, 32: write data to flash controller.
- f_we_o, output, 1: write enable to flash controller.
- f_stb_o, output, 1: strobe to flash controller.
- f_dat_i, input, 32: flash read data.
- f_ack_i, input, 1: flash acknowledge.
- f_rty_i, input, 1: flash retry (device busy).
- busy_o, output, 1: high whenever state != IDLE.
- grant_o, output, 1: index of the current or last granted requester.

Behaviour:
Reset:
- All outputs 0; state IDLE.
- Retry, timeout and release counters 0.
- last_grant = 1, so port 0 has first priority after reset.
- Reset mid-transaction drops f_stb_o on the next edge. No ack/err pulse is issued for the aborted transaction.

States:
- IDLE
  - If exactly one mX_stb_i is high, grant it.
  - If both are high, grant the port != last_grant.
  - On grant, latch adr/dat/we into internal registers, set grant_o and last_grant, clear retry_cnt, go to ISSUE.
  - Grant decision takes 1 cycle: f_stb_o rises 2 cycles after mX_stb_i is sampled.
- ISSUE
  - Assert f_stb_o with the latched fields, clear timeout_cnt, go to WAIT.
- WAIT
  - f_stb_o stays high; timeout_cnt increments every cycle.
  - f_ack_i: capture f_dat_i into mX_dat_o (granted port only), pulse mX_ack_o next cycle, go to RELEASE.
  - f_rty_i with retry_cnt < MAX_RETRIES: increment retry_cnt, go to BACKOFF.
  - f_rty_i with retry_cnt == MAX_RETRIES: pulse mX_err_o, go to RELEASE.
  - timeout_cnt == TIMEOUT-1 with no response: pulse mX_err_o, go to RELEASE.
  - f_ack_i and f_rty_i in the same cycle: ack wins.
- BACKOFF
  - f_stb_o low; count RETRY_DELAY cycles, then go to ISSUE.
  - BACKOFF length already exceeds RELEASE_CYCLES.
- RELEASE
  - f_stb_o low; count RELEASE_CYCLES, then go to IDLE.
  - The just-served port's stb_i is ignored during RELEASE. It is also masked in the first IDLE cycle if still high (requester lag).

Output and handshake rules:
- f_adr_o, f_dat_o and f_we_o come only from the latched registers, stable while f_stb_o is high.
- Requester inputs changing mid-transaction have no effect.
- A requester dropping stb mid-transaction does not abort the transaction. The ack/err pulse is still generated.
- mX_dat_o holds its value until the next ack to that port.
- Ack and err pulses are exactly 1 cycle and never both high.
- The ungranted port's outputs stay 0 throughout.
- Counter widths: clog2(param+1) each, no wrap. Counters saturate at their terminal value and then transition state.

Test Plan:
1. Single read: m0 read adr=0x000100; flash acks after 200 cycles with 0xDEADBEEF. Required: m0_dat_o=0xDEADBEEF, m0_ack_o high for 1 cycle, f_stb_o low for 16 cycles, busy_o low afterwards.
2. Contention: m0_stb_i and m1_stb_i rise in the same cycle, both held.
   - Required: m0 is served first (after reset), then m1.
   - Repeat both requests: m1 is served before m0.
   - f_adr_o changes only while f_stb_o is low.
3. Retry: flash returns rty 3 times, then ack.
   - Required: 4 f_stb_o assertions, each separated by ≥1000 low cycles.
   - Single m1_ack_o; m1_err_o never asserted.
4. Retry exhaustion: flash always returns rty. Required: 16 strobes (1 initial + 15 retries), then a 1-cycle m0_err_o and no m0_ack_o.
5. Timeout and reset:
   - Flash never responds: m0_err_o at cycle 65535 of WAIT, then f_stb_o low.
   - Separately, assert rst_i during WAIT: f_stb_o=0 next cycle, no ack/err, next grant goes to m0.
